imem_fetch_ctrl: RTL and testbench

- Sequencer and arbiter for the 128-word instruction memory.
- Owns the memory address port and shares it between two clients: a boot loader that streams program words in, and the fetch path that walks the program counter.
- Delivers fetched instructions to the decode stage over a valid/ready handshake and accepts branch/jump redirects.
- Sits between the instruction memory and the decode stage.

---
 rtl/imem_fetch_ctrl_pkg.sv | 27 ++
 rtl/imem_fetch_ctrl_fetch_stage.sv | 54 +++++
 rtl/imem_fetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_fetch_ctrl_pkg
//   Values shared by the fetch controller, the decode stage and the bench:
//   controller state encoding, instruction memory geometry, the PC a program
//   starts from after a load, and the NOP encoding used as the idle value of
//   the fetched-instruction register.
package imem_fetch_ctrl_pkg;

    localparam int          IM_DEPTH    = 128;
    localparam int          IM_AW       = 32;
    localparam int          IM_DW       = 32;
    localparam logic [31:0] IM_RESET_PC = 32'h0;
    localparam logic [31:0] NOP_INST    = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } fetch_state_t;

    // The load counter carries one bit beyond the memory index range.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fetch_stage.sv
// imem_fetch_stage
//   Output register between the instruction memory and decode. Holds one
//   fetched instruction and its word address under a valid/ready handshake.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_flush      drop the held instruction (redirect, load, fault)
//     i_load       capture i_inst/i_pc as a new valid instruction
//     i_inst/i_pc  instruction word and its word address from memory
//     i_ready      decode accepts the held instruction
//     o_valid/o_inst/o_pc  held instruction towards decode
module imem_fetch_stage
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int AW = IM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_load,
    input  logic [31:0]   i_inst,
    input  logic [AW-1:0] i_pc,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [31:0]   o_inst,
    output logic [AW-1:0] o_pc
);

    logic          r_vld_p1;
    logic [31:0]   r_inst_p1;
    logic [AW-1:0] r_pc_p1;

    // ---- memory read -> decode boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_inst_p1 <= NOP_INST;
            r_pc_p1   <= '0;
        end else if (i_flush) begin
            r_vld_p1 <= 1'b0;
        end else if (i_load) begin
            r_vld_p1  <= 1'b1;
            r_inst_p1 <= i_inst;
            r_pc_p1   <= i_pc;
        end else if (i_ready) begin
            // Accepted with nothing new behind it (halt): the slot empties.
            r_vld_p1 <= 1'b0;
        end
    end

    assign o_valid = r_vld_p1;
    assign o_inst  = r_inst_p1;
    assign o_pc    = r_pc_p1;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Sequencer/arbiter for the word-addressed instruction memory. The memory
//   port is owned by the boot loader in LOAD and by the program counter in
//   RUN/HALTED; fetched words go to decode through imem_fetch_stage.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     ld_start/ld_valid/ld_data/ld_last/ld_ready   loader stream
//     im_addr/im_we/im_wdata/im_rdata  instruction memory port (rdata is
//                                      combinational from im_addr)
//     if_valid/if_ready/if_inst/if_pc  fetched instruction to decode
//     redirect_valid/redirect_pc       branch/jump target (word index)
//     halt                             level request to stop fetching
//     busy_load                        high while loading
//     fault                            sticky error, cleared only by reset
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int            DEPTH    = IM_DEPTH,
    parameter int            AW       = IM_AW,
    parameter logic [AW-1:0] RESET_PC = AW'(IM_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW-1:0] im_addr,
    output logic          im_we,
    output logic [31:0]   im_wdata,
    input  logic [31:0]   im_rdata,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [31:0]   if_inst,
    output logic [AW-1:0] if_pc,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          busy_load,
    output logic          fault
);

    localparam int CW = cnt_width(DEPTH);

    fetch_state_t  r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [CW-1:0] r_ld_cnt, w_cnt_nxt;
    logic          w_flush, w_load, w_can_adv, w_if_valid;

    // Output slot is free or being emptied this cycle.
    assign w_can_adv = !w_if_valid || if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_ld_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ld_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_ld_cnt;
        w_flush     = 1'b0;
        w_load      = 1'b0;
        ld_ready    = 1'b0;
        busy_load   = 1'b0;
        fault       = 1'b0;
        im_we       = 1'b0;
        im_addr     = '0;
        im_wdata    = '0;

        case (r_state)
            ST_IDLE: begin
                if (ld_start) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end
            end

            ST_LOAD: begin
                busy_load = 1'b1;
                ld_ready  = 1'b1;
                w_flush   = 1'b1;
                im_addr   = AW'(r_ld_cnt);
                if (ld_valid) begin
                    im_we     = 1'b1;
                    im_wdata  = ld_data;
                    w_cnt_nxt = r_ld_cnt + CW'(1);
                    if (ld_last) begin
                        w_state_nxt = ST_RUN;
                        w_pc_nxt    = RESET_PC;
                    end else if (r_ld_cnt == CW'(DEPTH - 1)) begin
                        // Program overflows memory: last slot is still written.
                        w_state_nxt = ST_FAULT;
                    end
                end
            end

            ST_RUN: begin
                im_addr = r_pc;
                if (ld_start) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                    w_flush     = 1'b1;
                end else if (redirect_valid) begin
                    // Target is range-checked only when it is fetched.
                    w_pc_nxt = redirect_pc;
                    w_flush  = 1'b1;
                end else if (w_can_adv) begin
                    if (halt) begin
                        w_state_nxt = ST_HALTED;
                    end else if (r_pc >= AW'(DEPTH)) begin
                        w_state_nxt = ST_FAULT;
                        w_flush     = 1'b1;
                    end else begin
                        w_load   = 1'b1;
                        w_pc_nxt = r_pc + AW'(1);
                    end
                end
            end

            ST_HALTED: begin
                im_addr = r_pc;
                if (ld_start) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                    w_flush     = 1'b1;
                end else begin
                    if (redirect_valid) begin
                        // Held instruction is on the abandoned path.
                        w_pc_nxt = redirect_pc;
                        w_flush  = 1'b1;
                    end
                    if (!halt) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_FAULT: begin
                fault   = 1'b1;
                w_flush = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_flush     = 1'b1;
            end
        endcase
    end

    imem_fetch_stage #(
        .AW (AW)
    ) u_fetch_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_load  (w_load),
        .i_inst  (im_rdata),
        .i_pc    (r_pc),
        .i_ready (if_ready),
        .o_valid (w_if_valid),
        .o_inst  (if_inst),
        .o_pc    (if_pc)
    );

    assign if_valid = w_if_valid;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_ready;
    logic [AW-1:0] im_addr;
    logic          im_we;
    logic [31:0]   im_wdata, im_rdata;
    logic          if_valid;
    logic          if_ready = 1'b1;
    logic [31:0]   if_inst;
    logic [AW-1:0] if_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;
    logic          busy_load, fault;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } xact_t;

    xact_t wq[$];   // expected memory writes
    xact_t fq[$];   // expected instructions accepted by decode

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prog4 [0:3];
    logic [31:0] mem   [0:127];

    imem_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready),
        .im_addr(im_addr), .im_we(im_we), .im_wdata(im_wdata), .im_rdata(im_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .busy_load(busy_load), .fault(fault)
    );

    always #5 clk = ~clk;

    // Instruction memory model: synchronous write, combinational read.
    initial for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    always @(posedge clk) if (im_we && im_addr < 128) mem[im_addr[6:0]] <= im_wdata;
    assign im_rdata = (im_addr < 128) ? mem[im_addr[6:0]] : 32'h0;

    // Scoreboard: sampled mid-cycle, the following rising edge commits what is seen.
    always @(negedge clk) begin
        if (rst_n) begin
            if (im_we) begin
                n_checks++;
                if (wq.size() == 0) begin
                    $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", im_addr, im_wdata);
                end else begin
                    xact_t e;
                    e = wq.pop_front();
                    if (im_addr !== e.a || im_wdata !== e.d)
                        $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", im_addr, im_wdata, e.a, e.d);
                    else n_pass++;
                end
            end
            if (if_valid && if_ready) begin
                n_checks++;
                if (fq.size() == 0) begin
                    $display("FAIL fetch_unexpected: got pc=%0d inst=%h, required none", if_pc, if_inst);
                end else begin
                    xact_t e;
                    e = fq.pop_front();
                    if (if_pc !== e.a || if_inst !== e.d)
                        $display("FAIL fetch: got pc=%0d inst=%h, required pc=%0d inst=%h", if_pc, if_inst, e.a, e.d);
                    else n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ld_start = 0; ld_valid = 0; ld_last = 0; redirect_valid = 0; halt = 0; if_ready = 1;
        tick(); tick();
        rst_n = 1'b1;
        wq.delete(); fq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if_valid, im_we, ld_ready, busy_load, fault} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, required 00000", {if_valid, im_we, ld_ready, busy_load, fault});
        else n_pass++;
        n_checks++;
        if (if_inst !== NOP_INST || if_pc !== '0 || im_addr !== '0 || im_wdata !== '0)
            $display("FAIL reset_data: got inst=%h pc=%0d addr=%0d wdata=%h, required zeros", if_inst, if_pc, im_addr, im_wdata);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        ld_valid = 1; halt = 1; redirect_valid = 1;   // ignored in IDLE
        tick();
        ld_valid = 0; halt = 0; redirect_valid = 0;
        n_checks++;
        if (busy_load !== 1'b0 || ld_ready !== 1'b0 || if_valid !== 1'b0)
            $display("FAIL idle_ignore: got busy=%b rdy=%b vld=%b, required 0 0 0", busy_load, ld_ready, if_valid);
        else n_pass++;
    endtask

    task automatic test_load_run_stall();
        do_reset();
        ld_start = 1; tick(); ld_start = 0;
        n_checks++;
        if (busy_load !== 1'b1 || ld_ready !== 1'b1)
            $display("FAIL load_enter: got busy=%b rdy=%b, required 1 1", busy_load, ld_ready);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            wq.push_back('{a: 32'(i), d: prog4[i]});
            ld_valid = 1; ld_data = prog4[i]; ld_last = (i == 3);
            tick();
        end
        ld_valid = 0; ld_last = 0;
        n_checks++;
        if (busy_load !== 1'b0 || if_valid !== 1'b0 || wq.size() != 0)
            $display("FAIL run_enter: got busy=%b vld=%b pending_writes=%0d, required 0 0 0", busy_load, if_valid, wq.size());
        else n_pass++;
        fq.push_back('{a: 32'd0, d: prog4[0]});
        fq.push_back('{a: 32'd1, d: prog4[1]});
        tick(); tick();
        if_ready = 0;
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd1)
            $display("FAIL pc1_out: got vld=%b pc=%0d, required 1 1", if_valid, if_pc);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'd1 || if_inst !== prog4[1] || im_addr !== 32'd2)
                $display("FAIL stall_hold: got vld=%b pc=%0d inst=%h addr=%0d, required 1 1 %h 2", if_valid, if_pc, if_inst, im_addr, prog4[1]);
            else n_pass++;
        end
        fq.push_back('{a: 32'd2, d: prog4[2]});
        if_ready = 1;
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd2 || if_inst !== prog4[2])
            $display("FAIL stall_release: got vld=%b pc=%0d inst=%h, required 1 2 %h", if_valid, if_pc, if_inst, prog4[2]);
        else n_pass++;
    endtask

    task automatic test_redirect_fault();
        redirect_valid = 1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 0; if_ready = 0;
        n_checks++;
        if (if_valid !== 1'b0)
            $display("FAIL redirect_flush: got vld=%b, required 0", if_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_inst !== prog4[0])
            $display("FAIL redirect_target: got vld=%b pc=%0d inst=%h, required 1 0 %h", if_valid, if_pc, if_inst, prog4[0]);
        else n_pass++;
        redirect_valid = 1; redirect_pc = 32'd3;
        tick();
        redirect_valid = 0;
        n_checks++;
        if (if_valid !== 1'b0)
            $display("FAIL redirect_stall_flush: got vld=%b, required 0", if_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd3 || if_inst !== prog4[3])
            $display("FAIL redirect3: got vld=%b pc=%0d inst=%h, required 1 3 %h", if_valid, if_pc, if_inst, prog4[3]);
        else n_pass++;
        fq.push_back('{a: 32'd3, d: prog4[3]});
        if_ready = 1; redirect_valid = 1; redirect_pc = 32'd200;
        tick();
        redirect_valid = 0;
        n_checks++;
        if (fault !== 1'b0 || if_valid !== 1'b0)
            $display("FAIL redirect200_pre: got fault=%b vld=%b, required 0 0", fault, if_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (fault !== 1'b1 || if_valid !== 1'b0 || ld_ready !== 1'b0 || im_we !== 1'b0)
            $display("FAIL oob_fault: got fault=%b vld=%b rdy=%b we=%b, required 1 0 0 0", fault, if_valid, ld_ready, im_we);
        else n_pass++;
        ld_start = 1; tick(); ld_start = 0; tick();
        n_checks++;
        if (fault !== 1'b1 || busy_load !== 1'b0)
            $display("FAIL fault_sticky: got fault=%b busy=%b, required 1 0", fault, busy_load);
        else n_pass++;
        n_checks++;
        if (fq.size() != 0)
            $display("FAIL fetch_drain: got %0d pending, required 0", fq.size());
        else n_pass++;
        rst_n = 0; #1;
        n_checks++;
        if (fault !== 1'b0)
            $display("FAIL fault_reset: got fault=%b, required 0", fault);
        else n_pass++;
        rst_n = 1;
    endtask

    task automatic load128(input bit with_last);
        do_reset();
        ld_start = 1; tick(); ld_start = 0;
        for (int i = 0; i < 128; i++) begin
            wq.push_back('{a: 32'(i), d: 32'hA500_0000 | 32'(i)});
            ld_valid = 1; ld_data = 32'hA500_0000 | 32'(i); ld_last = with_last && (i == 127);
            if (with_last && i == 127) begin halt = 1; if_ready = 0; end
            tick();
        end
        ld_valid = 0; ld_last = 0;
    endtask

    task automatic test_overflow();
        load128(1'b0);
        ld_valid = 1; ld_data = 32'hDEAD_BEEF;   // must not be written in FAULT
        tick();
        ld_valid = 0;
        n_checks++;
        if (fault !== 1'b1 || busy_load !== 1'b0 || wq.size() != 0)
            $display("FAIL overflow: got fault=%b busy=%b pending_writes=%0d, required 1 0 0", fault, busy_load, wq.size());
        else n_pass++;
    endtask

    task automatic test_full_load_halt();
        load128(1'b1);
        n_checks++;
        if (fault !== 1'b0 || busy_load !== 1'b0 || wq.size() != 0)
            $display("FAIL full_load: got fault=%b busy=%b pending_writes=%0d, required 0 0 0", fault, busy_load, wq.size());
        else n_pass++;
        tick(); tick();
        n_checks++;
        if (if_valid !== 1'b0 || im_addr !== 32'd0)
            $display("FAIL halted: got vld=%b addr=%0d, required 0 0", if_valid, im_addr);
        else n_pass++;
        halt = 0; tick(); tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_inst !== 32'hA500_0000)
            $display("FAIL resume: got vld=%b pc=%0d inst=%h, required 1 0 a5000000", if_valid, if_pc, if_inst);
        else n_pass++;
        halt = 1; tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0)
            $display("FAIL halt_hold: got vld=%b pc=%0d, required 1 0", if_valid, if_pc);
        else n_pass++;
        fq.push_back('{a: 32'd0, d: 32'hA500_0000});
        if_ready = 1; tick(); tick();
        n_checks++;
        if (if_valid !== 1'b0 || im_addr !== 32'd1 || fq.size() != 0)
            $display("FAIL halt_drain: got vld=%b addr=%0d pending=%0d, required 0 1 0", if_valid, im_addr, fq.size());
        else n_pass++;
        ld_start = 1; tick(); ld_start = 0; halt = 0;
        n_checks++;
        if (busy_load !== 1'b1)
            $display("FAIL halted_to_load: got busy=%b, required 1", busy_load);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        do_reset();
        ld_start = 1; tick(); ld_start = 0;
        for (int i = 0; i < 2; i++) begin
            wq.push_back('{a: 32'(i), d: 32'h1111_0000 | 32'(i)});
            ld_valid = 1; ld_data = 32'h1111_0000 | 32'(i);
            tick();
        end
        ld_data = 32'h1111_0002;
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({im_we, busy_load, ld_ready, fault, if_valid} !== 5'b0 || im_addr !== '0 || im_wdata !== '0)
            $display("FAIL async_reset: got ctl=%b addr=%0d wdata=%h, required 00000 0 0", {im_we, busy_load, ld_ready, fault, if_valid}, im_addr, im_wdata);
        else n_pass++;
        ld_valid = 0;
        tick(); tick();
        rst_n = 1;
        ld_start = 1; tick(); ld_start = 0;
        n_checks++;
        if (busy_load !== 1'b1 || im_addr !== 32'd0)
            $display("FAIL reload_start: got busy=%b addr=%0d, required 1 0", busy_load, im_addr);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            wq.push_back('{a: 32'(i), d: 32'h2222_0000 | 32'(i)});
            ld_valid = 1; ld_data = 32'h2222_0000 | 32'(i); ld_last = (i == 1);
            tick();
        end
        ld_valid = 0; ld_last = 0; if_ready = 0;
        tick();
        n_checks++;
        if (wq.size() != 0 || if_valid !== 1'b1 || if_inst !== 32'h2222_0000)
            $display("FAIL reload: got pending_writes=%0d vld=%b inst=%h, required 0 1 22220000", wq.size(), if_valid, if_inst);
        else n_pass++;
    endtask

    initial begin
        prog4[0] = 32'h8C00_0010;
        prog4[1] = 32'hAC00_0004;
        prog4[2] = 32'h1000_0002;
        prog4[3] = 32'h0000_0020;
        test_reset();
        test_load_run_stall();
        test_redirect_fault();
        test_overflow();
        test_full_load_halt();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
